alu_uart_core: RTL and testbench

//  Parametrised-width successor of the 4-bit ALU block. Holds A/B operands

---
 rtl/alu_uart_core_if.sv | 24 ++
 rtl/alu_uart_core.sv | 123 ++++++++++++
 tb/tb_alu_uart_core.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_core_if.sv
// alu_uart_core_if: operand/control bus and result/UART outputs of the ALU core.
// Signals:
//   save_a_n, save_b_n  active-low operand load strobes
//   data_in             operand bus
//   op_sel              operation select
//   tx_start            rising edge requests a UART frame
//   result, flags       registered ALU result and {V,N,C,Z}
//   uart_txd, uart_busy serial line (idle high) and frame-in-progress
// Modports: master drives the controls and observes the outputs; slave is the core.
interface alu_uart_if #(parameter int WIDTH = 8);
  logic             save_a_n;
  logic             save_b_n;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       op_sel;
  logic             tx_start;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             uart_txd;
  logic             uart_busy;
  modport master (output save_a_n, save_b_n, data_in, op_sel, tx_start,
                  input result, flags, uart_txd, uart_busy);
  modport slave (input save_a_n, save_b_n, data_in, op_sel, tx_start,
                 output result, flags, uart_txd, uart_busy);
endinterface

// File: rtl/alu_uart_core.sv
// alu_uart_core: WIDTH-bit 16-op ALU with Z/C/N/V flags and an 8N1 UART result sender.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      alu_uart_if.slave: operand loads, op select, tx trigger, result/flags, UART line
// A frame is ceil(WIDTH/8) result bytes (LSB byte first) followed by {4'b0,V,N,C,Z}.
module alu_uart_core #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset_n,
  alu_uart_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int SW = $clog2(WIDTH);
  localparam int NB = (WIDTH + 7) / 8;
  localparam int FW = (NB + 1) * 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int YW = $clog2(NB + 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [3:0] flg_q, flg_d;
  logic [WIDTH:0] ax, bx, sum, dif, inc, dec, shl, shr;
  logic signed [WIDTH:0] sar;
  logic [SW-1:0] s;
  logic c, v;
  logic [FW-1:0] frame_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [YW-1:0] byte_q;
  logic tx_prev_q, tick, accept;
  assign ax = {1'b0, a_q};
  assign bx = {1'b0, b_q};
  assign s  = b_q[SW-1:0];
  // Shifts run one bit wider so the last bit moved out lands in the extra bit.
  always_comb begin
    sum = ax + bx;
    dif = ax - bx;
    inc = ax + ONE;
    dec = ax - ONE;
    shl = ax << s;
    shr = {a_q, 1'b0} >> s;
    sar = $signed({a_q, 1'b0}) >>> s;
    res_d = '0;
    c = 1'b0;
    v = 1'b0;
    case (bus.op_sel)
      4'h0: begin res_d = sum[M:0]; c = sum[WIDTH]; v = (a_q[M] == b_q[M]) && (res_d[M] != a_q[M]); end
      4'h1: begin res_d = dif[M:0]; c = dif[WIDTH]; v = (a_q[M] != b_q[M]) && (res_d[M] != a_q[M]); end
      4'h2: res_d = a_q & b_q;
      4'h3: res_d = a_q | b_q;
      4'h4: res_d = a_q ^ b_q;
      4'h5: res_d = ~a_q;
      4'h6: begin res_d = shl[M:0]; c = shl[WIDTH]; end
      4'h7: begin res_d = shr[WIDTH:1]; c = shr[0]; end
      4'h8: begin res_d = sar[WIDTH:1]; c = sar[0]; end
      4'h9: begin res_d = {a_q[M-1:0], a_q[M]}; c = a_q[M]; end
      4'hA: begin res_d = {a_q[0], a_q[M:1]}; c = a_q[0]; end
      4'hB: begin res_d = inc[M:0]; c = inc[WIDTH]; v = !a_q[M] && res_d[M]; end
      4'hC: begin res_d = dec[M:0]; c = dec[WIDTH]; v = a_q[M] && !res_d[M]; end
      4'hD: res_d = a_q * b_q;
      4'hE: res_d = {{M{1'b0}}, a_q < b_q};
      default: res_d = b_q;
    endcase
    flg_d = {v, res_d[M], c, res_d == '0};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (!bus.save_a_n) a_q <= bus.data_in;
      if (!bus.save_b_n) b_q <= bus.data_in;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
  assign bus.result = res_q;
  assign bus.flags  = flg_q;
  assign tick   = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign accept = state_q == IDLE && bus.tx_start && !tx_prev_q;
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (accept ? START : IDLE) :
              state_q == START ? (tick ? DATA : START) :
              state_q == DATA  ? (tick && bit_q == 3'd7 ? STOP : DATA) :
                                 (tick ? (byte_q == YW'(NB) ? IDLE : START) : STOP);
  end
  always_comb begin
    bus.uart_txd  = state_q == START ? 1'b0 : state_q == DATA ? frame_q[0] : 1'b1;
    bus.uart_busy = state_q != IDLE;
  end
  // The snapshot shifts right once per data bit, so the byte on the wire is always frame_q[7:0].
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      frame_q   <= '0;
      tx_prev_q <= 1'b0;
    end else begin
      tx_prev_q <= bus.tx_start;
      cnt_q     <= (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      if (accept) begin
        frame_q <= {4'b0, flg_q, (NB*8)'(res_q)};
        byte_q  <= '0;
      end
      if (state_q == DATA && tick) begin
        frame_q <= frame_q >> 1;
        bit_q   <= bit_q + 1'b1;
      end
      if (state_q == STOP && tick) byte_q <= byte_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_uart_core.sv
// tb_alu_uart_core: directed scoreboard bench for alu_uart_core at WIDTH 8 and 12.
module tb_alu_uart_core;
  localparam int CPB  = 4;
  localparam int BIT  = CPB * 10;
  localparam int HALF = BIT / 2 + 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  alu_uart_if #(.WIDTH(8))  bus8();
  alu_uart_if #(.WIDTH(12)) bus12();
  alu_uart_core #(.WIDTH(8),  .CLKS_PER_BIT(CPB)) u8  (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));
  alu_uart_core #(.WIDTH(12), .CLKS_PER_BIT(CPB)) u12 (.clk(clk), .reset_n(reset_n), .bus(bus12.slave));
  logic [1:0] txd;
  assign txd = {bus12.uart_txd, bus8.uart_txd};
  int total = 0;
  int bad = 0;
  logic alu_chk = 1'b0;
  logic mon_en = 1'b1;
  logic [11:0] exp_alu[$];
  logic [7:0] exp8[$];
  logic [7:0] exp12[$];
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic expect_alu(input logic [7:0] er, input logic [3:0] ef);
    #1;
    exp_alu.push_back({er, ef});
    alu_chk = 1'b1;
    @(negedge clk);
    #1 alu_chk = 1'b0;
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                     input logic [7:0] er, input logic [3:0] ef);
    bus8.data_in = a;
    bus8.save_a_n = 1'b0;
    @(negedge clk);
    bus8.save_a_n = 1'b1;
    bus8.data_in = b;
    bus8.save_b_n = 1'b0;
    bus8.op_sel = op;
    @(negedge clk);
    bus8.save_b_n = 1'b1;
    @(negedge clk);
    expect_alu(er, ef);
  endtask
  always @(negedge clk) begin : alu_mon
    logic [11:0] e;
    if (alu_chk) begin
      total++;
      if (exp_alu.size() == 0) begin
        bad++;
        $display("FAIL alu: got res=%h flg=%b want nothing queued", bus8.result, bus8.flags);
      end else begin
        e = exp_alu.pop_front();
        if ({bus8.result, bus8.flags} !== e) begin
          bad++;
          $display("FAIL alu: got res=%h flg=%b want res=%h flg=%b", bus8.result, bus8.flags, e[11:4], e[3:0]);
        end
      end
    end
  end
  task automatic uart_mon(input int ch);
    logic [7:0] d;
    logic [7:0] e;
    logic ok;
    logic en;
    forever begin
      wait (txd[ch] == 1'b0);
      en = mon_en;
      #HALF ok = (txd[ch] == 1'b0);
      for (int i = 0; i < 8; i++) begin
        #BIT d[i] = txd[ch];
      end
      #BIT ok = ok && txd[ch];
      if (en) begin
        total++;
        if ((ch == 1 ? exp12.size() : exp8.size()) == 0) begin
          bad++;
          $display("FAIL uart%0d: got byte %h want no frame", ch, d);
        end else begin
          if (ch == 1) e = exp12.pop_front();
          else         e = exp8.pop_front();
          if (d !== e || !ok) begin
            bad++;
            $display("FAIL uart%0d: got byte %h framing_ok=%b want byte %h framing_ok=1", ch, d, ok, e);
          end
        end
      end
    end
  endtask
  initial uart_mon(0);
  initial uart_mon(1);
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int n;
    int m;
    bus8.save_a_n = 1'b1;  bus8.save_b_n = 1'b1;  bus8.data_in = '0;  bus8.op_sel = '0;  bus8.tx_start = 1'b0;
    bus12.save_a_n = 1'b1; bus12.save_b_n = 1'b1; bus12.data_in = '0; bus12.op_sel = '0; bus12.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", bus8.uart_txd, 1);
    check("rst_busy", bus8.uart_busy, 0);
    expect_alu(8'h00, 4'h0);
    reset_n = 1'b1;
    run(8'h7F, 8'h01, 4'h0, 8'h80, 4'hC);
    run(8'h00, 8'h01, 4'h1, 8'hFF, 4'h6);
    run(8'h00, 8'h01, 4'hC, 8'hFF, 4'h6);
    run(8'h81, 8'h00, 4'h9, 8'h03, 4'h2);
    run(8'h81, 8'h03, 4'h8, 8'hF0, 4'h4);
    run(8'h81, 8'h01, 4'h6, 8'h02, 4'h2);
    run(8'hC0, 8'h07, 4'h7, 8'h01, 4'h2);
    run(8'h01, 8'h00, 4'hA, 8'h80, 4'h6);
    run(8'hFF, 8'h00, 4'hB, 8'h00, 4'h3);
    run(8'h0F, 8'h11, 4'hD, 8'hFF, 4'h4);
    run(8'h03, 8'h05, 4'hE, 8'h01, 4'h0);
    run(8'h5A, 8'hFF, 4'h2, 8'h5A, 4'h0);
    exp8.push_back(8'h5A);
    exp8.push_back(8'h00);
    bus8.tx_start = 1'b1;
    @(negedge clk);
    bus8.data_in = 8'h11;
    bus8.save_a_n = 1'b0;
    n = 0;
    while (bus8.uart_busy && n < 200) begin
      n++;
      @(negedge clk);
      bus8.save_a_n = 1'b1;
    end
    check("busy_len", n, 80);
    m = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus8.uart_busy) m++;
    end
    check("no_retrigger", m, 0);
    bus8.tx_start = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    bus8.tx_start = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_txd_pre", bus8.uart_txd, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_txd", bus8.uart_txd, 1);
    check("abort_busy", bus8.uart_busy, 0);
    expect_alu(8'h00, 4'h0);
    reset_n = 1'b1;
    bus8.tx_start = 1'b0;
    repeat (120) @(negedge clk);
    mon_en = 1'b1;
    bus12.data_in = 12'hABC;
    bus12.op_sel = 4'hF;
    bus12.save_a_n = 1'b0;
    bus12.save_b_n = 1'b0;
    @(negedge clk);
    bus12.save_a_n = 1'b1;
    bus12.save_b_n = 1'b1;
    repeat (2) @(negedge clk);
    check("res12", bus12.result, 12'hABC);
    check("flg12", bus12.flags, 4'h4);
    exp12.push_back(8'hBC);
    exp12.push_back(8'h0A);
    exp12.push_back(8'h04);
    bus12.tx_start = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus12.uart_busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("busy12_len", n, 120);
    n = 0;
    while ((exp8.size() + exp12.size() + exp_alu.size()) != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("drained", exp8.size() + exp12.size() + exp_alu.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
